// File: rtl/mdu_xu.sv
// mdu_xu: E-stage multiply/divide unit with architectural HI/LO registers.
//   Runs mult/multu/div/divu with a fixed latency, serves mfhi/mflo through
//   rd, accepts mthi/mtlo writes, and raises the D-stage stall while busy.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   a, b            rs / rt operands (E stage)
//   st, op          start request and operation select (0 multu, 1 mult, 2 divu, 3 div)
//   we              mthi/mtlo write; op[0] selects HI
//   kill            E-stage squash; suppresses st and we this cycle
//   use_d           D-stage instruction touches HI/LO
//   rd              op[0] ? hi : lo (combinational)
//   busy            operation in flight
//   stall           D-stage stall (combinational)
//   hi, lo          architectural HI / LO
module mdu_xu #(
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        st,
   input  logic [1:0]  op,
   input  logic        we,
   input  logic        kill,
   input  logic        use_d,
   output logic [31:0] rd,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [31:0]        stg_hi, stg_hi_nx;
   logic [31:0]        stg_lo, stg_lo_nx;
   logic               stg_ok, stg_ok_nx;
   logic [31:0]        hi_nx, lo_nx;

   // Multiply datapath: the low 64 bits of the product of the extended
   // operands equal the signed or unsigned 64-bit product.
   logic [63:0] ext_a, ext_b, prod;

   always_comb begin
      ext_a = op[0] ? {{32{a[31]}}, a} : {32'd0, a};
      ext_b = op[0] ? {{32{b[31]}}, b} : {32'd0, b};
      prod  = ext_a * ext_b;
   end

   // Divide datapath: divide magnitudes, then restore signs. The quotient is
   // negated when operand signs differ; the remainder follows the dividend.
   // 0x80000000 / -1 falls out naturally as 0x80000000 remainder 0.
   logic        neg_a, neg_b;
   logic [31:0] mag_a, mag_b, dvs, uq, ur, quo, rem;

   always_comb begin
      neg_a = op[0] & a[31];
      neg_b = op[0] & b[31];
      mag_a = neg_a ? (~a + 32'd1) : a;
      mag_b = neg_b ? (~b + 32'd1) : b;
      // Divisor forced nonzero so the datapath stays defined; commit is blocked.
      dvs   = (b == 32'd0) ? 32'd1 : mag_b;
      uq    = mag_a / dvs;
      ur    = mag_a % dvs;
      quo   = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
      rem   = neg_a ? (~ur + 32'd1) : ur;
   end

   // Next-state and register-update logic.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      stg_hi_nx = stg_hi;
      stg_lo_nx = stg_lo;
      stg_ok_nx = stg_ok;
      hi_nx     = hi;
      lo_nx     = lo;

      unique case (state)
         S_IDLE: begin
            if (st && !kill) begin
               state_nx = S_BUSY;
               if (op[1]) begin
                  cnt_nx    = CNT_W'(DIV_LAT);
                  stg_hi_nx = rem;
                  stg_lo_nx = quo;
                  stg_ok_nx = (b != 32'd0);
               end else begin
                  cnt_nx    = CNT_W'(MUL_LAT);
                  stg_hi_nx = prod[63:32];
                  stg_lo_nx = prod[31:0];
                  stg_ok_nx = 1'b1;
               end
            end else if (we && !kill) begin
               if (op[0]) hi_nx = a;
               else       lo_nx = a;
            end
         end
         S_BUSY: begin
            // st/we are ignored here; kill has no effect on the in-flight op.
            cnt_nx = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_nx = S_IDLE;
               if (stg_ok) begin
                  hi_nx = stg_hi;
                  lo_nx = stg_lo;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State and architectural registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         stg_hi <= '0;
         stg_lo <= '0;
         stg_ok <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         stg_hi <= stg_hi_nx;
         stg_lo <= stg_lo_nx;
         stg_ok <= stg_ok_nx;
         hi     <= hi_nx;
         lo     <= lo_nx;
      end
   end

   // Outputs.
   assign busy  = (state == S_BUSY);
   assign rd    = op[0] ? hi : lo;
   assign stall = use_d & (busy | (st & ~kill));

endmodule

// File: tb/tb_mdu_xu.sv
// tb_mdu_xu: directed self-checking bench for mdu_xu (MUL_LAT=5, DIV_LAT=10).
module tb_mdu_xu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a, b;
   logic        st, we, kill, use_d;
   logic [1:0]  op;
   logic [31:0] rd, hi, lo;
   logic        busy, stall;

   int checks = 0;
   int errors = 0;

   mdu_xu #(.MUL_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .st(st), .op(op), .we(we),
      .kill(kill), .use_d(use_d), .rd(rd), .busy(busy), .stall(stall),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clear_inputs();
      st = 1'b0; we = 1'b0; kill = 1'b0;
   endtask

   // Issue one start and return the number of busy cycles observed.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int n);
      step();
      op = o; a = x; b = y; st = 1'b1; #1;
      @(posedge clk); #1;
      st = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         step();
      end
   endtask

   task automatic write_hilo(input logic to_hi, input logic [31:0] v);
      step();
      we = 1'b1; op = {1'b0, to_hi}; a = v;
      step();
      we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear_inputs(); use_d = 1'b1; op = 2'd0; a = '0; b = '0;
      #12;
      checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL reset_hi got %h exp %h", hi, 32'd0); end
      checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL reset_lo got %h exp %h", lo, 32'd0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
      rst_n = 1'b1;
      write_hilo(1'b1, 32'h55);
      write_hilo(1'b0, 32'h66);
      checks++; if (hi !== 32'h55) begin errors++; $display("FAIL pre_reset_hi got %h exp %h", hi, 32'h55); end
      // Start a mult and abort it with a mid-cycle reset two cycles later.
      step();
      op = 2'd1; a = 32'hFFFF_FFFE; b = 32'd3; st = 1'b1;
      step();
      st = 1'b0;
      step();
      #3 rst_n = 1'b0;
      #1;
      checks++; if (hi !== 32'd0)   begin errors++; $display("FAIL midreset_hi got %h exp %h", hi, 32'd0); end
      checks++; if (lo !== 32'd0)   begin errors++; $display("FAIL midreset_lo got %h exp %h", lo, 32'd0); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midreset_stall got %b exp 0", stall); end
      #3 rst_n = 1'b1;
      repeat (10) step();
      checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL abort_hi got %h exp %h", hi, 32'd0); end
      checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL abort_lo got %h exp %h", lo, 32'd0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
   endtask

   task automatic test_mult();
      int n;
      use_d = 1'b0;
      run_op(2'd1, 32'hFFFF_FFFE, 32'd3, n);
      checks++; if (n !== 5) begin errors++; $display("FAIL mult_lat got %0d exp 5", n); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
      checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", lo); end
      op = 2'd1; #1;
      checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mfhi_rd got %h exp ffffffff", rd); end
      op = 2'd0; #1;
      checks++; if (rd !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mflo_rd got %h exp fffffffa", rd); end
      run_op(2'd0, 32'hFFFF_FFFE, 32'd3, n);
      checks++; if (n !== 5) begin errors++; $display("FAIL multu_lat got %0d exp 5", n); end
      checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got %h exp 00000002", hi); end
      checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got %h exp fffffffa", lo); end
   endtask

   task automatic test_div();
      int n;
      run_op(2'd3, 32'hFFFF_FFF9, 32'd2, n);
      checks++; if (n !== 10) begin errors++; $display("FAIL div_lat got %0d exp 10", n); end
      checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", lo); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi); end
      run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
      checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h exp 80000000", lo); end
      checks++; if (hi !== 32'h0000_0000) begin errors++; $display("FAIL divovf_hi got %h exp 00000000", hi); end
      run_op(2'd2, 32'd100, 32'd7, n);
      checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h exp 0000000e", lo); end
      checks++; if (hi !== 32'd2)  begin errors++; $display("FAIL divu_hi got %h exp 00000002", hi); end
   endtask

   task automatic test_div_zero();
      int n;
      write_hilo(1'b1, 32'h11);
      write_hilo(1'b0, 32'h22);
      run_op(2'd2, 32'h1234, 32'd0, n);
      checks++; if (n !== 10) begin errors++; $display("FAIL divz_lat got %0d exp 10", n); end
      checks++; if (hi !== 32'h11) begin errors++; $display("FAIL divz_hi got %h exp 00000011", hi); end
      checks++; if (lo !== 32'h22) begin errors++; $display("FAIL divz_lo got %h exp 00000022", lo); end
   endtask

   task automatic test_stall();
      int n;
      use_d = 1'b1;
      step();
      op = 2'd0; a = 32'd4; b = 32'd5; st = 1'b1; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_start got %b exp 1", stall); end
      @(posedge clk); #1;
      st = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         #1;
         checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_busy%0d got %b exp 1", n, stall); end
         n++;
         // Requests during busy, then a kill: none may disturb the in-flight op.
         if (n == 1 || n == 2) begin
            st = 1'b1; we = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
         end else if (n == 3) begin
            st = 1'b0; we = 1'b0; kill = 1'b1;
         end else begin
            kill = 1'b0;
         end
         step();
      end
      clear_inputs();
      #1;
      checks++; if (n !== 5) begin errors++; $display("FAIL stall_lat got %0d exp 5", n); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_after got %b exp 0", stall); end
      checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL busyreq_hi got %h exp 00000000", hi); end
      checks++; if (lo !== 32'd20) begin errors++; $display("FAIL busyreq_lo got %h exp 00000014", lo); end
   endtask

   task automatic test_kill();
      write_hilo(1'b1, 32'hAAAA);
      write_hilo(1'b0, 32'hBBBB);
      use_d = 1'b1;
      step();
      st = 1'b1; kill = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL kill_stall got %b exp 0", stall); end
      step();
      clear_inputs();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %b exp 0", busy); end
      step();
      checks++; if (hi !== 32'hAAAA) begin errors++; $display("FAIL kill_hi got %h exp 0000aaaa", hi); end
      checks++; if (lo !== 32'hBBBB) begin errors++; $display("FAIL kill_lo got %h exp 0000bbbb", lo); end
      we = 1'b1; kill = 1'b1; op = 2'd1; a = 32'h1234;
      step();
      clear_inputs();
      checks++; if (hi !== 32'hAAAA) begin errors++; $display("FAIL killwe_hi got %h exp 0000aaaa", hi); end
      we = 1'b1; op = 2'd1; a = 32'hDEAD_BEEF;
      step();
      we = 1'b0;
      checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_hi got %h exp deadbeef", hi); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_rd got %h exp deadbeef", rd); end
      checks++; if (lo !== 32'hBBBB) begin errors++; $display("FAIL mthi_lo got %h exp 0000bbbb", lo); end
   endtask

   task automatic test_priority();
      int n;
      use_d = 1'b0;
      step();
      st = 1'b1; we = 1'b1; op = 2'd1; a = 32'd2; b = 32'd3;
      step();
      clear_inputs();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_busy got %b exp 1", busy); end
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         step();
      end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL prio_hi got %h exp 00000000", hi); end
      checks++; if (lo !== 32'd6) begin errors++; $display("FAIL prio_lo got %h exp 00000006", lo); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_stall();
      test_kill();
      test_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
